// File: rtl/tile_addr_pipe.sv
// Two-stage pixel-to-tile address generator with valid/ready flow control.
// Stage 1 splits (x,y) into tile column/row and sub-offsets; stage 2 forms the record address and new-tile flag.
module tile_addr_pipe #(
  parameter int COORD_W        = 11,
  parameter int ADDR_W         = 16,
  parameter int H_ACTIVE       = 640,
  parameter int V_TOP          = 80,
  parameter int V_BOTTOM       = 480,
  parameter int TILE_W_LOG2    = 5,
  parameter int TILE_H_LOG2    = 3,
  parameter int TILES_PER_ROW  = 20,
  parameter int WORDS_PER_TILE = 16,
  parameter int BASE_ADDR      = 16384,
  parameter int OOB_ADDR       = 32384
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [COORD_W-1:0]     x,
  input  logic [COORD_W-1:0]     y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W-1:0]      address,
  output logic [TILE_W_LOG2-1:0] px_in_tile,
  output logic [TILE_H_LOG2-1:0] row_in_tile,
  output logic                   oob,
  output logic                   new_tile
);

  localparam int COL_W = COORD_W - TILE_W_LOG2;
  localparam int ROW_W = COORD_W - TILE_H_LOG2;
  localparam logic [COORD_W-1:0] H_LIM   = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_LO    = COORD_W'(V_TOP);
  localparam logic [COORD_W-1:0] V_HI    = COORD_W'(V_BOTTOM);
  localparam logic [ADDR_W-1:0]  OOB_VAL = ADDR_W'(OOB_ADDR);

  function automatic logic [ADDR_W-1:0] tile_addr(input logic [ROW_W-1:0] r,
                                                  input logic [COL_W-1:0] c);
    logic [ADDR_W-1:0] idx;
    idx = ADDR_W'(r) * ADDR_W'(TILES_PER_ROW) + ADDR_W'(c);
    return ADDR_W'(BASE_ADDR) + idx * ADDR_W'(WORDS_PER_TILE);
  endfunction

  logic                   advance;
  logic [COORD_W-1:0]     y_rel;
  logic                   vld_p1, in_reg_p1;
  logic [COL_W-1:0]       col_p1;
  logic [ROW_W-1:0]       row_p1;
  logic [TILE_W_LOG2-1:0] px_p1;
  logic [TILE_H_LOG2-1:0] sub_p1;
  logic                   vld_p2;
  logic                   trk_vld;
  logic [ADDR_W-1:0]      trk_addr;
  logic                   out_xfer;
  logic                   last_vld;
  logic [ADDR_W-1:0]      last_addr;
  logic [ADDR_W-1:0]      addr_calc;

  assign advance   = !vld_p2 || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_p2;
  assign y_rel     = y - V_LO;

  // Stage 1: region test and coordinate split
  always_ff @(posedge clk) begin
    if (reset) vld_p1 <= 1'b0;
    else if (advance) vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      in_reg_p1 <= (y >= V_LO) && (y < V_HI) && (x < H_LIM);
      col_p1    <= x[COORD_W-1:TILE_W_LOG2];
      row_p1    <= y_rel[COORD_W-1:TILE_H_LOG2];
      px_p1     <= x[TILE_W_LOG2-1:0];
      sub_p1    <= y_rel[TILE_H_LOG2-1:0];
    end
  end

  // The result leaving this cycle is the "previous" one for the result entering stage 2.
  assign out_xfer  = vld_p2 && out_ready && !oob;
  assign last_vld  = trk_vld || out_xfer;
  assign last_addr = out_xfer ? address : trk_addr;
  assign addr_calc = tile_addr(row_p1, col_p1);

  // Stage 2: address formation, oob forcing, new-tile detection
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2      <= 1'b0;
      address     <= OOB_VAL;
      px_in_tile  <= '0;
      row_in_tile <= '0;
      oob         <= 1'b1;
      new_tile    <= 1'b0;
      trk_vld     <= 1'b0;
    end else begin
      if (out_xfer) begin
        trk_vld  <= 1'b1;
        trk_addr <= address;
      end
      if (advance) begin
        vld_p2      <= vld_p1;
        address     <= in_reg_p1 ? addr_calc : OOB_VAL;
        px_in_tile  <= in_reg_p1 ? px_p1 : '0;
        row_in_tile <= in_reg_p1 ? sub_p1 : '0;
        oob         <= !in_reg_p1;
        new_tile    <= in_reg_p1 && (!last_vld || (addr_calc != last_addr));
      end
    end
  end

endmodule

// File: tb/tb_tile_addr_pipe.sv
// Directed bench for tile_addr_pipe: reset, mapping, oob, streaming, stall and mid-stream reset.
module tb_tile_addr_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [10:0] x, y;
  logic [15:0] address;
  logic [4:0]  px_in_tile;
  logic [2:0]  row_in_tile;
  logic        oob, new_tile;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] a;
    logic [4:0]  px;
    logic [2:0]  r;
    logic        o;
    logic        nt;
  } res_t;
  res_t q[$];

  tile_addr_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .address(address), .px_in_tile(px_in_tile), .row_in_tile(row_in_tile),
    .oob(oob), .new_tile(new_tile)
  );

  always #5 clk = ~clk;

  // Capture every output-side transfer; signals are stable at the falling edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready)
      q.push_back('{a: address, px: px_in_tile, r: row_in_tile, o: oob, nt: new_tile});
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge, in_valid still high.
  task automatic send(input int xv, input int yv);
    int g;
    in_valid = 1'b1;
    x = 11'(xv);
    y = 11'(yv);
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_results(input int n);
    int g;
    g = 0;
    while (q.size() < n && g < 200) begin
      @(posedge clk);
      g++;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    tests++; if (address !== 16'd32384) begin fails++; $display("FAIL reset_address got %0d want 32384", address); end
    tests++; if (oob !== 1'b1 || new_tile !== 1'b0) begin fails++; $display("FAIL reset_flags got oob=%0b nt=%0b want oob=1 nt=0", oob, new_tile); end
    tests++; if (px_in_tile !== 5'd0 || row_in_tile !== 3'd0) begin fails++; $display("FAIL reset_offsets got px=%0d row=%0d want 0 0", px_in_tile, row_in_tile); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_first();
    q.delete();
    send(0, 80);
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL first_latency1 got out_valid=%0b want 0", out_valid); end
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL first_latency2 got out_valid=%0b want 1", out_valid); end
    tests++; if (address !== 16'd16384) begin fails++; $display("FAIL first_address got %0d want 16384", address); end
    tests++; if (px_in_tile !== 5'd0 || row_in_tile !== 3'd0 || oob !== 1'b0) begin fails++; $display("FAIL first_offsets got px=%0d row=%0d oob=%0b want 0 0 0", px_in_tile, row_in_tile, oob); end
    tests++; if (new_tile !== 1'b1) begin fails++; $display("FAIL first_new_tile got %0b want 1", new_tile); end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_corner();
    q.delete();
    send(639, 479);
    in_valid = 1'b0;
    wait_results(1);
    tests++;
    if (q.size() != 1) begin fails++; $display("FAIL corner_count got %0d want 1", q.size()); end
    else if (q[0].a !== 16'd32368 || q[0].px !== 5'd31 || q[0].r !== 3'd7 || q[0].o !== 1'b0)
      begin fails++; $display("FAIL corner_result got a=%0d px=%0d row=%0d oob=%0b want 32368 31 7 0", q[0].a, q[0].px, q[0].r, q[0].o); end
  endtask

  task automatic test_oob();
    q.delete();
    send(100, 50);
    send(640, 200);
    in_valid = 1'b0;
    wait_results(2);
    tests++; if (q.size() != 2) begin fails++; $display("FAIL oob_count got %0d want 2", q.size()); end
    for (int i = 0; i < q.size(); i++) begin
      tests++;
      if (q[i].a !== 16'd32384 || q[i].o !== 1'b1 || q[i].nt !== 1'b0 || q[i].px !== 5'd0 || q[i].r !== 3'd0)
        begin fails++; $display("FAIL oob_result%0d got a=%0d oob=%0b nt=%0b px=%0d row=%0d want 32384 1 0 0 0", i, q[i].a, q[i].o, q[i].nt, q[i].px, q[i].r); end
    end
  endtask

  task automatic test_boundaries();
    logic [15:0] ea[5];
    logic        eo[5];
    logic        en[5];
    logic [4:0]  ep[5];
    logic [2:0]  er[5];
    ea = '{16'd32384, 16'd32064, 16'd16688, 16'd32384, 16'd16688};
    eo = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    en = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    ep = '{5'd0, 5'd0, 5'd31, 5'd0, 5'd31};
    er = '{3'd0, 3'd7, 3'd0, 3'd0, 3'd0};
    q.delete();
    send(0, 79);
    send(0, 479);
    send(639, 80);
    send(640, 80);
    send(639, 80);
    in_valid = 1'b0;
    wait_results(5);
    tests++; if (q.size() != 5) begin fails++; $display("FAIL bound_count got %0d want 5", q.size()); end
    for (int i = 0; i < q.size() && i < 5; i++) begin
      tests++;
      if (q[i].a !== ea[i] || q[i].o !== eo[i] || q[i].nt !== en[i] || q[i].px !== ep[i] || q[i].r !== er[i])
        begin fails++; $display("FAIL bound_result%0d got a=%0d oob=%0b nt=%0b px=%0d row=%0d want %0d %0b %0b %0d %0d",
                                 i, q[i].a, q[i].o, q[i].nt, q[i].px, q[i].r, ea[i], eo[i], en[i], ep[i], er[i]); end
    end
  endtask

  task automatic test_back_to_back();
    q.delete();
    for (int i = 32; i < 64; i++) send(i, 88);
    in_valid = 1'b0;
    wait_results(32);
    tests++; if (q.size() != 32) begin fails++; $display("FAIL stream_count got %0d want 32", q.size()); end
    for (int i = 0; i < q.size() && i < 32; i++) begin
      tests++;
      if (q[i].a !== 16'd16720 || q[i].nt !== (i == 0) || q[i].px !== 5'(i) || q[i].r !== 3'd0 || q[i].o !== 1'b0)
        begin fails++; $display("FAIL stream_x%0d got a=%0d nt=%0b px=%0d row=%0d want 16720 %0b %0d 0", i + 32, q[i].a, q[i].nt, q[i].px, q[i].r, (i == 0), i); end
    end
  endtask

  task automatic test_stall();
    int  idx;
    logic acc;
    idx = 0;
    q.delete();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      x = 11'(idx * 32);
      y = 11'd160;
      @(negedge clk);
      acc = in_ready;
      if (c >= 2) begin
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || address !== 16'd19584)
          begin fails++; $display("FAIL stall_hold%0d got in_ready=%0b out_valid=%0b a=%0d want 0 1 19584", c, in_ready, out_valid, address); end
      end
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    tests++; if (idx != 2) begin fails++; $display("FAIL stall_accepts got %0d want 2", idx); end
    out_ready = 1'b1;
    wait_results(2);
    repeat (3) @(posedge clk); #1;
    tests++; if (q.size() != 2) begin fails++; $display("FAIL stall_count got %0d want 2", q.size()); end
    else begin
      tests++;
      if (q[0].a !== 16'd19584 || q[1].a !== 16'd19600 || q[0].nt !== 1'b1 || q[1].nt !== 1'b1)
        begin fails++; $display("FAIL stall_results got a0=%0d a1=%0d nt0=%0b nt1=%0b want 19584 19600 1 1", q[0].a, q[1].a, q[0].nt, q[1].nt); end
    end
  endtask

  task automatic test_reset_midstream();
    q.delete();
    out_ready = 1'b0;
    send(32, 160);
    send(32, 160);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midreset_out_valid got %0b want 0", out_valid); end
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midreset_ghost got %0b want 0", out_valid); end
    out_ready = 1'b1;
    q.delete();
    send(32, 160);
    in_valid = 1'b0;
    wait_results(1);
    tests++;
    if (q.size() != 1) begin fails++; $display("FAIL midreset_count got %0d want 1", q.size()); end
    else if (q[0].a !== 16'd19600 || q[0].nt !== 1'b1)
      begin fails++; $display("FAIL midreset_result got a=%0d nt=%0b want 19600 1", q[0].a, q[0].nt); end
  endtask

  initial begin
    test_reset();
    test_first();
    test_corner();
    test_oob();
    test_boundaries();
    test_back_to_back();
    test_stall();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
